// File: rtl/aska_spi_cfg_slave.sv
// aska_spi_cfg_slave: oversampled SPI (mode 0) slave that receives 8-bit address + DATA_W-bit
// data frames, writes the four ASKA configuration registers and optionally reads one back on MISO.
`default_nettype none

module aska_spi_cfg_slave #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              SPI_Clk,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS,
    output logic              SPI_MISO,
    output logic [DATA_W-1:0] conf0,
    output logic [DATA_W-1:0] conf1,
    output logic [DATA_W-1:0] ele1,
    output logic [DATA_W-1:0] ele2,
    output logic              cfg_update,
    output logic [1:0]        cfg_addr,
    output logic              frame_err
);

    localparam logic [5:0] FRAME_LEN = 6'(8 + DATA_W);
    localparam logic [5:0] CNT_MAX   = FRAME_LEN + 6'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;

    // CS synchronizer resets low so that a CS already low at reset release never looks like a fall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_Clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    state_t            state;
    logic [5:0]        bit_cnt;
    logic [DATA_W-1:0] shift_in;
    logic [7:0]        addr_q;
    logic [DATA_W-1:0] rd_shift;
    logic              rd_en;

    logic [7:0]        addr_next;
    logic [DATA_W-1:0] rd_sel;
    logic              addr_next_rd;
    logic              frame_ok;

    assign addr_next    = {shift_in[6:0], mosi_s};
    assign addr_next_rd = addr_next[7] && (addr_next[6:2] == 5'd0);
    assign frame_ok     = (bit_cnt == FRAME_LEN) && (addr_q[6:2] == 5'd0);

    always_comb begin
        rd_sel = conf0;
        case (addr_next[1:0])
            2'd0:    rd_sel = conf0;
            2'd1:    rd_sel = conf1;
            2'd2:    rd_sel = ele1;
            default: rd_sel = ele2;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_cnt    <= 6'd0;
            shift_in   <= '0;
            addr_q     <= 8'd0;
            rd_shift   <= '0;
            rd_en      <= 1'b0;
            SPI_MISO   <= 1'b0;
            conf0      <= '0;
            conf1      <= '0;
            ele1       <= '0;
            ele2       <= '0;
            cfg_update <= 1'b0;
            cfg_addr   <= 2'd0;
            frame_err  <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ADDR;
                        bit_cnt <= 6'd0;
                    end
                end
                ADDR: begin
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_in <= {shift_in[DATA_W-2:0], mosi_s};
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            addr_q <= addr_next;
                            state  <= DATA;
                            if (addr_next_rd) begin
                                rd_shift <= rd_sel;
                                SPI_MISO <= rd_sel[DATA_W-1];
                                rd_en    <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[DATA_W-2:0], mosi_s};
                            if (bit_cnt != CNT_MAX)
                                bit_cnt <= bit_cnt + 6'd1;
                        end
                        // The fall right after the 8th rise must keep the MSB on MISO for the 9th rise.
                        if (sclk_fall && rd_en && (bit_cnt >= 6'd9)) begin
                            rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                            SPI_MISO <= rd_shift[DATA_W-2];
                        end
                    end
                end
                default: begin
                    SPI_MISO <= 1'b0;
                    rd_en    <= 1'b0;
                    bit_cnt  <= 6'd0;
                    if (frame_ok && !addr_q[7]) begin
                        cfg_update <= 1'b1;
                        cfg_addr   <= addr_q[1:0];
                        case (addr_q[1:0])
                            2'd0:    conf0 <= shift_in;
                            2'd1:    conf1 <= shift_in;
                            2'd2:    ele1  <= shift_in;
                            default: ele2  <= shift_in;
                        endcase
                    end else if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end
                    state <= cs_fall ? ADDR : IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aska_spi_cfg_slave.sv
// tb_aska_spi_cfg_slave: directed frames with hand-computed expected register values.
`default_nettype none

module tb_aska_spi_cfg_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sclk, mosi, cs;
    logic        miso;
    logic [31:0] conf0, conf1, ele1, ele2;
    logic        upd, err;
    logic [1:0]  caddr;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    aska_spi_cfg_slave #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .SPI_Clk    (sclk),
        .SPI_MOSI   (mosi),
        .SPI_CS     (cs),
        .SPI_MISO   (miso),
        .conf0      (conf0),
        .conf1      (conf1),
        .ele1       (ele1),
        .ele2       (ele2),
        .cfg_update (upd),
        .cfg_addr   (caddr),
        .frame_err  (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd) upd_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sends nbits of {addr, data, 8'h00} MSB first; captures MISO before each data-phase rise and
    // samples cfg_update/frame_err one cycle before and exactly at the 4th clk edge after CS rises.
    task automatic frame(input logic [7:0] a, input logic [31:0] d, input int nbits,
                         output logic [31:0] rd, output logic pre_u, output logic pre_e,
                         output logic u4, output logic e4);
        logic [47:0] bits;
        bits = {a, d, 8'h00};
        rd   = 32'd0;
        cs   = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[47-i];
            repeat (HALF) @(negedge clk);
            if (i >= 8 && i < 40) rd = {rd[30:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        pre_u = upd;
        pre_e = err;
        @(negedge clk);
        u4 = upd;
        e4 = err;
        repeat (6) @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        pu, pe, u4, e4;
    int          u0, e0;

    initial begin
        resetn = 1'b0;
        sclk   = 1'b0;
        mosi   = 1'b0;
        cs     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_conf0", conf0, 32'd0);
        chk("rst_ele2", ele2, 32'd0);
        chk("rst_flags", {29'd0, miso, upd, err}, 32'd0);
        chk("rst_addr", {30'd0, caddr}, 32'd0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        frame(8'h02, 32'h0000_8000, 40, rd, pu, pe, u4, e4);
        chk("w2_pre_upd", {31'd0, pu}, 32'd0);
        chk("w2_upd", {31'd0, u4}, 32'd1);
        chk("w2_ele1", ele1, 32'h0000_8000);
        chk("w2_addr", {30'd0, caddr}, 32'd2);
        chk("w2_upd_single", {31'd0, upd}, 32'd0);

        frame(8'h03, 32'h0000_4000, 40, rd, pu, pe, u4, e4);
        chk("w3_upd", {31'd0, u4}, 32'd1);
        chk("w3_ele2", ele2, 32'h0000_4000);
        chk("w3_addr", {30'd0, caddr}, 32'd3);
        chk("w3_conf0", conf0, 32'd0);
        chk("w3_conf1", conf1, 32'd0);

        // conf0 = {ON[31:24]=50, ramp[23:16]=50, amp[15:10]=25, freq[9:0]=400}
        frame(8'h00, 32'h3232_6590, 40, rd, pu, pe, u4, e4);
        chk("w0_pre_upd", {31'd0, pu}, 32'd0);
        chk("w0_upd", {31'd0, u4}, 32'd1);
        chk("w0_conf0", conf0, 32'h3232_6590);
        chk("w0_on", {24'd0, conf0[31:24]}, 32'd50);
        chk("w0_freq", {22'd0, conf0[9:0]}, 32'd400);

        frame(8'h01, 32'h0090_0C98, 40, rd, pu, pe, u4, e4);
        chk("w1_upd", {31'd0, u4}, 32'd1);
        chk("w1_conf1", conf1, 32'h0090_0C98);
        chk("w1_addr", {30'd0, caddr}, 32'd1);

        u0 = upd_cnt;
        frame(8'h01, 32'hDEAD_BEEF, 32, rd, pu, pe, u4, e4);
        chk("short_pre_err", {31'd0, pe}, 32'd0);
        chk("short_err", {31'd0, e4}, 32'd1);
        chk("short_conf1", conf1, 32'h0090_0C98);
        chk("short_no_upd", upd_cnt - u0, 32'd0);

        frame(8'h00, 32'h1234_5678, 48, rd, pu, pe, u4, e4);
        chk("long_err", {31'd0, e4}, 32'd1);
        chk("long_conf0", conf0, 32'h3232_6590);

        frame(8'h05, 32'h1234_5678, 40, rd, pu, pe, u4, e4);
        chk("badaddr_err", {31'd0, e4}, 32'd1);
        chk("badaddr_conf1", conf1, 32'h0090_0C98);
        chk("badaddr_no_upd", upd_cnt - u0, 32'd0);

        e0 = err_cnt;
        frame(8'h82, 32'hFFFF_FFFF, 40, rd, pu, pe, u4, e4);
        chk("read_data", rd, 32'h0000_8000);
        chk("read_flags", {30'd0, u4, e4}, 32'd0);
        chk("read_ele1", ele1, 32'h0000_8000);
        chk("read_no_upd", upd_cnt - u0, 32'd0);
        chk("read_no_err", err_cnt - e0, 32'd0);
        chk("read_miso_idle", {31'd0, miso}, 32'd0);

        frame(8'h80, 32'h0, 40, rd, pu, pe, u4, e4);
        chk("read0_data", rd, 32'h3232_6590);

        // Abort a frame mid-way with reset, leaving CS low across the release.
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_conf0", conf0, 32'd0);
        chk("mid_rst_conf1", conf1, 32'd0);
        chk("mid_rst_ele", ele1 | ele2, 32'd0);
        chk("mid_rst_flags", {28'd0, caddr, upd, err}, 32'd0);
        e0 = err_cnt;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_no_err", err_cnt - e0, 32'd0);

        frame(8'h00, 32'hA5A5_A5A5, 40, rd, pu, pe, u4, e4);
        chk("post_rst_upd", {31'd0, u4}, 32'd1);
        chk("post_rst_conf0", conf0, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
